// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, parity selectors, line idle level.
// Parity helper takes the data zero-extended to 8 bits; extra zeros do not change the XOR.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ (odd == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// Rising-edge detector on the baud_gen square wave: one-cycle tick per baud_in rising edge.
// Combinational tick from the registered previous level; baud_in held high yields a single tick.
module uart_tick_detect (
    input  logic clock,
    input  logic rst,
    input  logic baud_in,
    output logic tick
);

    logic baud_prev;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            baud_prev <= 1'b0;
        end else begin
            baud_prev <= baud_in;
        end
    end

    assign tick = baud_in & ~baud_prev;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, DATA_WIDTH bits LSB-first, optional parity, STOP_BITS stop bits.
// Accept is a valid/ready handshake in IDLE; line bits advance one per baud tick, tx_out registered.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  baud_in,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int              CW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   BIT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tick;
    logic                  accept;

    uart_tick_detect u_tick (
        .clock   (clock),
        .rst     (rst),
        .baud_in (baud_in),
        .tick    (tick)
    );

    // Masking with tx_done keeps ready low in the done cycle so it reasserts one cycle later.
    assign tx_ready = (state == IDLE) && !tx_done;
    assign accept   = tx_valid & tx_ready;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out    <= LINE_IDLE;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= LINE_IDLE;
                    if (accept) begin
                        shift     <= tx_data;
                        par_en_q  <= parity_en;
                        par_bit_q <= parity_bit(8'(tx_data), parity_odd);
                        busy      <= 1'b1;
                        state     <= SYNC;
                    end
                end
                SYNC: begin
                    tx_out <= LINE_IDLE;
                    if (tick) begin
                        state  <= START;
                        tx_out <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx_out  <= shift[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            if (par_en_q) begin
                                state  <= PARITY;
                                tx_out <= par_bit_q;
                            end else begin
                                state    <= STOP;
                                tx_out   <= LINE_IDLE;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + CW'(1);
                            tx_out  <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state    <= STOP;
                        tx_out   <= LINE_IDLE;
                        stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    tx_out <= LINE_IDLE;
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= LINE_IDLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
